// File: rtl/adc_disp_pkg.sv
// Shared definitions for the ADC millivolt display path.
// Contents:
//   - Conversion widths and iteration counts.
//   - FSM state codes, kept as plain 2-bit constants.
//   - dabble_adjust(): the add-3 correction applied before each double-dabble shift.
package adc_disp_pkg;

  localparam int unsigned MUL_STEPS  = 8;
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned PROD_W     = 22;
  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StMul   = 2'd1;
  localparam state_t StRound = 2'd2;
  localparam state_t StBcd   = 2'd3;

  // Add 3 to every BCD digit that is 5 or more.
  // After the following shift, such a digit carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Iterative binary-to-BCD converter (double dabble), one iteration per cycle.
// Timing: a start pulse loads the operand. The next BIN_W cycles each perform one
// add-3/shift step.
// Ports:
//   sysclk   - clock
//   reset    - synchronous active-high reset
//   start_i  - load bin_i and begin a conversion
//   bin_i    - 14-bit binary operand
//   bcd_o    - 4-digit BCD result, valid while done_o is high
//   done_o   - high during the final iteration cycle
// Output behaviour: bcd_o is the post-shift value of the current iteration. The parent can
// therefore capture the result on the same edge that completes the last step.
module bcd_double_dabble
  import adc_disp_pkg::*;
(
  input  logic              sysclk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic [BCD_W-1:0]  bcd_o,
  output logic              done_o
);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q;
  logic             run_q;
  logic [BCD_W+BIN_W-1:0] shifted;

  always_comb begin
    shifted = {dabble_adjust(bcd_q), bin_q} << 1;
    bcd_d   = shifted[BCD_W+BIN_W-1:BIN_W];
    bin_d   = shifted[BIN_W-1:0];
  end

  assign done_o = run_q && (cnt_q == 4'(BIN_W - 1));
  assign bcd_o  = bcd_d;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 4'd1;
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_mv_bcd.sv
// Converts 8-bit PCF8591 ADC codes into a 4-digit BCD millivolt value for the
// 7-segment driver.
// Conversion: mv = (code*VREF_MV + 128) >> 8.
//   - Scaling uses an 8-step shift-add multiplier.
//   - The rounding step is followed by a 14-step double dabble.
// Latency: 24 cycles from in_valid to out_valid.
// Pending buffer: one entry, holding the latest sample that arrived while busy.
// Optional feature: define ADC_AVG_EN to apply a 4-sample moving average to incoming samples.
// Ports:
//   sysclk    - 50 MHz clock
//   reset     - synchronous active-high reset
//   in_valid  - strobe, in_data holds a new ADC code
//   in_data   - ADC code 0..255
//   bcd_out   - {thousands, hundreds, tens, units}
//   out_valid - one-cycle pulse when bcd_out updates
//   busy      - conversion in progress
module adc_mv_bcd
  import adc_disp_pkg::*;
#(
  parameter int unsigned VREF_MV = 3300
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [15:0] bcd_out,
  output logic        out_valid,
  output logic        busy
);

  localparam logic [PROD_W-1:0] VrefExt = PROD_W'(VREF_MV);

  state_t            state_q, state_d;
  logic [7:0]        code_q, code_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [2:0]        step_q, step_d;
  logic              pend_valid_q, pend_valid_d;
  logic [7:0]        pend_code_q, pend_code_d;
  logic [15:0]       bcd_out_q, bcd_out_d;
  logic              out_valid_q, out_valid_d;

  logic [7:0]        new_code;
  logic [BIN_W-1:0]  mv;
  logic [BCD_W-1:0]  dd_bcd;
  logic              dd_done;

`ifdef ADC_AVG_EN
  // The three previous samples are stored.
  // Together with in_data they form the 4-entry window.
  logic [7:0] hist0_q, hist1_q, hist2_q;
  logic       hist_init_q;
  logic [9:0] sum;

  always_comb begin
    if (hist_init_q) begin
      sum = {2'b00, in_data} + {2'b00, hist0_q} + {2'b00, hist1_q} + {2'b00, hist2_q};
    end else begin
      sum = {in_data, 2'b00};
    end
    new_code = 8'(sum >> 2);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      hist0_q     <= '0;
      hist1_q     <= '0;
      hist2_q     <= '0;
      hist_init_q <= 1'b0;
    end else if (in_valid) begin
      hist_init_q <= 1'b1;
      hist0_q     <= in_data;
      hist1_q     <= hist_init_q ? hist0_q : in_data;
      hist2_q     <= hist_init_q ? hist1_q : in_data;
    end
  end
`else
  assign new_code = in_data;
`endif

  // Rounding and the >>8 truncation happen in the single ROUND cycle.
  assign mv = BIN_W'((prod_q + PROD_W'(128)) >> 8);

  bcd_double_dabble u_dabble (
    .sysclk  (sysclk),
    .reset   (reset),
    .start_i (state_q == StRound),
    .bin_i   (mv),
    .bcd_o   (dd_bcd),
    .done_o  (dd_done)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    mcand_d      = mcand_q;
    prod_d       = prod_q;
    step_d       = step_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    bcd_out_d    = bcd_out_q;
    out_valid_d  = 1'b0;

    if (in_valid && (state_q != StIdle)) begin
      pend_valid_d = 1'b1;
      pend_code_d  = new_code;
    end

    unique case (state_q)
      StIdle: begin
        // A fresh sample takes priority.
        // Any pending sample is older, so it is discarded.
        if (in_valid || pend_valid_q) begin
          code_d       = in_valid ? new_code : pend_code_q;
          pend_valid_d = 1'b0;
          mcand_d      = VrefExt;
          prod_d       = '0;
          step_d       = '0;
          state_d      = StMul;
        end
      end
      StMul: begin
        if (code_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        code_d  = code_q >> 1;
        step_d  = step_q + 3'd1;
        if (step_q == 3'(MUL_STEPS - 1)) begin
          state_d = StRound;
        end
      end
      StRound: state_d = StBcd;
      StBcd: begin
        if (dd_done) begin
          bcd_out_d   = dd_bcd;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= StIdle;
      code_q       <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
      step_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      bcd_out_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      mcand_q      <= mcand_d;
      prod_q       <= prod_d;
      step_q       <= step_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      bcd_out_q    <= bcd_out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bcd_out   = bcd_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adc_mv_bcd.sv
module tb_adc_mv_bcd;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [15:0] bo [3];
  logic        ov [3];
  logic        bz [3];

  int total = 0;
  int bad   = 0;
  int vref [3] = '{3300, 5000, 9999};

  always #5 sysclk = ~sysclk;

  adc_mv_bcd #(.VREF_MV(3300)) dut0 (
    .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .bcd_out(bo[0]), .out_valid(ov[0]), .busy(bz[0])
  );
  adc_mv_bcd #(.VREF_MV(5000)) dut1 (
    .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .bcd_out(bo[1]), .out_valid(ov[1]), .busy(bz[1])
  );
  adc_mv_bcd #(.VREF_MV(9999)) dut2 (
    .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .bcd_out(bo[2]), .out_valid(ov[2]), .busy(bz[2])
  );

  typedef struct {
    int          code;
    logic [15:0] exp [3];
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the edge (start of next cycle).
  task automatic tick(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge sysclk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference computed straight from the arithmetic rule; decimal digits via div/mod.
  function automatic logic [15:0] model_bcd(input int code, input int vr);
    int mv;
    logic [3:0] d3, d2, d1, d0;
    mv = ((code * vr + 128) >> 8) % 16384;
    d3 = 4'(mv / 1000);
    d2 = 4'((mv / 100) % 10);
    d1 = 4'((mv / 10) % 10);
    d0 = 4'(mv % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick(1'b0, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    vec_t tbl [5];
    int   n;
    int   pulses;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;

    tbl[0].code = 0;   tbl[0].exp = '{16'h0000, 16'h0000, 16'h0000};
    tbl[1].code = 1;   tbl[1].exp = '{16'h0013, 16'h0020, 16'h0039};
    tbl[2].code = 128; tbl[2].exp = '{16'h1650, 16'h2500, 16'h5000};
    tbl[3].code = 255; tbl[3].exp = '{16'h3287, 16'h4980, 16'h9960};
    tbl[4].code = 100; tbl[4].exp = '{16'h1289, 16'h1953, 16'h3906};

    do_reset();
    for (int k = 0; k < 3; k++) begin
      check("reset_bcd", 32'(bo[k]), 32'h0);
      check("reset_ov", 32'(ov[k]), 32'h0);
      check("reset_busy", 32'(bz[k]), 32'h0);
    end

`ifndef ADC_AVG_EN
    // Directed table: value and exact 24-cycle latency.
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'(tbl[i].code));
      check("busy_after_start", 32'(bz[0]), 32'h1);
      n = 1;
      while (!ov[0] && n < 40) begin
        tick(1'b0, 8'd0);
        n++;
      end
      check("latency", 32'(n), 32'd24);
      for (int k = 0; k < 3; k++) begin
        check("table_bcd", 32'(bo[k]), 32'(tbl[i].exp[k]));
      end
      check("ov_alone", 32'(ov[1] && ov[2]), 32'h1);
      tick(1'b0, 8'd0);
      check("ov_one_cycle", 32'(ov[0]), 32'h0);
      check("bcd_hold", 32'(bo[0]), 32'(tbl[i].exp[0]));
    end

    // Pending: 100@0, 200@5, 50@10 -> 0x1289@24, 0x0645@48, 200 dropped.
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      tick(c == 0 || c == 5 || c == 10,
           (c == 0) ? 8'd100 : (c == 5) ? 8'd200 : 8'd50);
      if (ov[0]) begin
        pulses++;
        if (pulses == 1) begin
          check("pend_t1", 32'(c + 1), 32'd24);
          check("pend_v1", 32'(bo[0]), 32'h1289);
        end else begin
          check("pend_t2", 32'(c + 1), 32'd48);
          check("pend_v2", 32'(bo[0]), 32'h0645);
        end
      end
    end
    check("pend_pulses", 32'(pulses), 32'd2);
`endif

    // Reset at cycle 10 of a code-255 conversion aborts it.
    tick(1'b1, 8'd255);
    repeat (9) tick(1'b0, 8'd0);
    reset = 1'b1;
    tick(1'b0, 8'd0);
    reset = 1'b0;
    check("abort_bcd", 32'(bo[0]), 32'h0);
    check("abort_busy", 32'(bz[0]), 32'h0);
    check("abort_ov", 32'(ov[0]), 32'h0);
    pulses = 0;
    repeat (30) begin
      tick(1'b0, 8'd0);
      if (ov[0]) pulses++;
    end
    check("abort_no_ov", 32'(pulses), 32'd0);

`ifdef ADC_AVG_EN
    // Moving average: 200, 0, 0, 0 spaced 30 cycles apart after reset.
    begin
      logic [15:0] aexp [4] = '{16'h2578, 16'h1934, 16'h1289, 16'h0645};
      do_reset();
      pulses = 0;
      for (int c = 0; c < 125; c++) begin
        tick((c % 30) == 0 && c < 120, (c == 0) ? 8'd200 : 8'd0);
        if (ov[0]) begin
          if (pulses < 4) begin
            check("avg_val", 32'(bo[0]), 32'(aexp[pulses]));
            check("avg_t", 32'(c + 1), 32'(30 * pulses + 24));
          end
          pulses++;
        end
      end
      check("avg_pulses", 32'(pulses), 32'd4);
    end
`else
    // Randomized traffic against an event-level model.
    // Modelled events: conversions start when idle, each lasts 24 cycles, and the
    // single pending slot keeps the latest sample.
    begin
      int          free_at = 0;
      int          due = -1;
      logic        pv = 1'b0;
      int          pc = 0;
      logic [15:0] expv [3];
      logic [15:0] lastv [3];
      logic        v;
      int          d;
      int          src;
      for (int k = 0; k < 3; k++) begin
        lastv[k] = 16'h0;
        expv[k]  = 16'h0;
      end
      for (int c = 0; c < 1500; c++) begin
        v = ($urandom_range(0, 9) == 0);
        d = int'($urandom_range(0, 255));
        src = -1;
        if (c >= free_at) begin
          if (v) src = d;
          else if (pv) src = pc;
          if (src >= 0) begin
            pv      = 1'b0;
            free_at = c + 24;
            due     = c + 24;
            for (int k = 0; k < 3; k++) expv[k] = model_bcd(src, vref[k]);
          end
        end else if (v) begin
          pv = 1'b1;
          pc = d;
        end
        tick(v, 8'(d));
        if (c + 1 == due) begin
          for (int k = 0; k < 3; k++) lastv[k] = expv[k];
        end
        check("rnd_ov", 32'(ov[0]), 32'(c + 1 == due));
        check("rnd_busy", 32'(bz[0]), 32'(c + 1 < free_at));
        for (int k = 0; k < 3; k++) check("rnd_bcd", 32'(bo[k]), 32'(lastv[k]));
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_mv_bcd.md
# adc_mv_bcd

Converts each 8-bit sample from the PCF8591 I2C reader into a 4-digit BCD millivolt value for the 7-segment dynamic driver's 16-bit `data` input. Sits between `pcf8591` (`reg_ADData`) and `seg_dynamic_drive`, replacing the raw hex display with a decimal voltage. Scaling uses a sequential shift-add multiplier, and binary-to-BCD conversion is iterative double-dabble. A one-deep pending register absorbs samples that arrive while a conversion is running.

## Interface
- `VREF_MV`, default 3300: full-scale reference in mV; legal range 1..9999.
- `sysclk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe: `in_data` holds a new ADC code.
- `in_data`  in  8  ADC code, 0..255.
- `bcd_out`  out  16  `[15:12]` thousands, `[11:8]` hundreds, `[7:4]` tens, `[3:0]` units; feeds `seg_dynamic_drive.data`.
- `out_valid`  out  1  one-cycle pulse when `bcd_out` updates.
- `busy`  out  1  high while a conversion is in progress.
- Clocking and reset: one clock, `sysclk`. Reset `reset` is synchronous and active-high.

## Operation
- Scaling rule: `mv = (code*VREF_MV + 128) >> 8`.
  - Product is 22 bits wide; `mv` is truncated to 14 bits (max 9960).
- State machine states:
  - IDLE: waits for a sample.
  - MUL: 8 cycles, shift-add over code bits LSB-first.
  - ROUND: 1 cycle, adds 128 and shifts right by 8.
  - BCD: 14 cycles of double-dabble (add-3 to any digit ≥5, then shift).
- Transitions:
  - IDLE→MUL on `in_valid`, or on pending-valid if no `in_valid` this cycle.
  - MUL→ROUND after 8 steps.
  - ROUND→BCD.
  - BCD→IDLE after 14 iterations; on that edge, load `bcd_out` and pulse `out_valid`.
- Pending buffer:
  - `in_valid` while not in IDLE stores the sample in a one-deep pending register. A newer sample overwrites an older one (latest wins).
  - Pending is cleared when consumed.
  - `in_valid` in IDLE starts immediately and does not touch pending.
  - `in_valid` in IDLE while pending is valid: the new sample starts and pending is discarded.
- `bcd_out` holds its last value between conversions.
- Reset values:
  - `bcd_out` = 0x0000, `out_valid` = 0, `busy` = 0.
  - State = IDLE; pending cleared.
- Reset mid-conversion aborts the conversion: no `out_valid`, `bcd_out` returns to 0x0000.

## Timing
- `in_valid` sampled in cycle 0 (IDLE):
  - `busy` is high in cycles 1..23.
  - `out_valid` and the new `bcd_out` appear in cycle 24.
- Fixed latency is 24 cycles; throughput is one conversion per 24 cycles.
- In cycle 24 the state is IDLE, so a new `in_valid` or a pending sample starts there. Back-to-back `out_valid` pulses are therefore 24 cycles apart.
- `out_valid` is exactly one cycle wide and is never asserted during reset.

## Configuration
- `ADC_AVG_EN` defined:
  - A 4-sample moving average is applied to accepted samples before scaling: `code = (s0+s1+s2+s3) >> 2`, with a 10-bit sum.
  - The history updates on every `in_valid`, including samples later overwritten in pending.
  - The first `in_valid` after reset fills all 4 history entries with that sample.
  - The history clears on reset.
- `ADC_AVG_EN` undefined: `code = in_data` latched directly. No history registers exist.

## Structure
- Shared package `adc_disp_pkg`:
  - state enum (IDLE, MUL, ROUND, BCD).
  - `MUL_STEPS = 8`, `BIN_W = 14`, `PROD_W = 22`, `BCD_DIGITS = 4`.
- One sub-module, `bcd_double_dabble`:
  - Takes a 14-bit binary input and a start signal; returns 16-bit BCD and done.
  - Fixed 14 iterations, one per cycle.
  - Owned by the BCD state.
- Scaling and pending logic stay in the top module.

## Test plan
- Code 0 → `bcd_out` 0x0000. Code 1 → 0x0013. Code 255 → 0x3287. Code 128 → 0x1650. Each `out_valid` is exactly 24 cycles after `in_valid`.
- `in_valid` 100 @ cycle 0, 200 @ cycle 5, 50 @ cycle 10 → 0x1289 @ cycle 24, then 0x0645 @ cycle 48. Sample 200 never appears.
- Assert `reset` at cycle 10 of a conversion of code 255 → no `out_valid`; `bcd_out` = 0x0000 and `busy` = 0 on the next cycle.
- `VREF_MV` = 5000, code 255 → 0x4980. `VREF_MV` = 9999, code 255 → 0x9960.
- With `ADC_AVG_EN`: `in_valid` 200, then 0, 0, 0, each 30 cycles apart → outputs for avg codes 200, 150, 100, 50 → 0x2578, 0x1934, 0x1289, 0x0645.
